branch_outcome_tracker: RTL
===========================

Name: branch_outcome_tracker

Overview:
Sits between fetch/decode and the execute-stage branch unit and forms the other end of the bimodal predictor's update interface. It records every prediction made by the predictor (PC, predicted direction) in an in-order queue. When execute resolves the oldest branch, it compares the actual outcome against the recorded prediction. It then drives the predictor's update_en/update_val/PC training inputs and signals mispredicts so that younger wrong-path entries are squashed.

Parameters:
DEPTH, 8, in-flight prediction queue entries; must be a power of two and at least 2.
PC_W, 32, PC width; must match the predictor PC port width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
pred_val  input  1  fetch presents a new predicted branch.
pred_rdy  output  1  queue can accept an entry; equals !full and has no dependence on resolve_val.
pred_pc  input  PC_W  PC of the predicted branch.
pred_taken  input  1  direction predicted by the predictor.
resolve_val  input  1  execute presents the outcome of the oldest branch.
resolve_rdy  output  1  equals !empty; there is no bypass from the enqueue side.
resolve_taken  input  1  actual branch direction.
flush  input  1  external pipeline flush (e.g. exception); discards all entries.
update_en  output  1  train the predictor this cycle.
update_val  output  1  actual direction to train with.
update_pc  output  PC_W  PC to index the predictor PHT during the update.
mispredict  output  1  one-cycle pulse; the resolved branch was mispredicted.
num_branches  output  32  count of resolved branches.
num_mispredicts  output  32  count of mispredicted branches.

Behaviour:
- Handshakes:
  - Enqueue fires when pred_val && pred_rdy.
  - Dequeue fires when resolve_val && resolve_rdy.
  - Each entry stores {pc, taken}.
- Queue: circular buffer with head/tail pointers of log2(DEPTH) bits plus a count register of log2(DEPTH)+1 bits. Pointers wrap from DEPTH-1 to 0.
- Simultaneous enqueue and dequeue, not full and not empty: both occur and count is unchanged.
- When full, pred_rdy=0 even if a dequeue fires in the same cycle.
- Outputs are registered; latency is 1 cycle from the dequeue fire edge:
  - update_en=1, update_val=resolve_taken, update_pc=head.pc.
  - mispredict=(resolve_taken != head.taken).
  - All of these are held for exactly one cycle, then update_en=0 and mispredict=0.
- update_pc and update_val hold their last values while update_en=0.
- Mispredict squash: on a dequeue fire with a mismatch, the whole queue empties at that edge (count=0, head=tail).
  - Any enqueue firing in the same cycle is discarded, because it is wrong-path.
  - The update for the resolved branch is still emitted.
- flush: empties the queue at the next edge and discards any same-cycle enqueue.
  - A dequeue firing in the same cycle as flush is still reported (update_en/mispredict next cycle).
- Counters at the dequeue fire:
  - num_branches increments by 1 on every dequeue.
  - num_mispredicts increments by 1 on each mismatch.
  - Both wrap modulo 2^32.
- Reset (async assert, any time, including mid-operation):
  - count=0, head=tail=0, pred_rdy=1, resolve_rdy=0.
  - update_en=0, update_val=0, update_pc=0, mispredict=0, both counters=0.
  - Queue storage contents need not be cleared.
- State: a two-state FSM, IDLE (count=0) and BUSY (count>0).
  - IDLE→BUSY on enqueue without squash/flush.
  - BUSY→IDLE on the last dequeue, a squash, or flush.
  - resolve_rdy=1 only in BUSY.

Optional Feature:
BRANCH_TRACKER_STATS_EN
- Defined: num_branches and num_mispredicts behave as specified above.
- Undefined: both counter outputs are tied to 0, no counter flops are instantiated, and all other behaviour is identical.

Test Plan:
- Reset, then enqueue pc=0x100 taken=1 and resolve taken=1 → next cycle update_en=1, update_pc=0x100, update_val=1, mispredict=0; num_branches=1.
- Fill 8 entries → pred_rdy=0. Simultaneous resolve plus pred_val → enqueue rejected, count=7, pred_rdy=1 next cycle.
- Enqueue pcs 0x200, 0x204, 0x208 all taken=0, then resolve 0x200 taken=1 → mispredict pulse with update_pc=0x200, update_val=1; queue empty, resolve_rdy=0; num_mispredicts=1.
- Back-to-back enqueue/dequeue 20 times with DEPTH=8 → pointers wrap, update_pc sequence matches enqueue order exactly.
- Assert flush with 3 entries queued and a same-cycle resolve of a correct branch → one update, mispredict=0, queue empty.
- Drop reset to 0 mid-stream with 5 entries queued → immediately count=0, pred_rdy=1, update_en=0, counters=0. Compile without BRANCH_TRACKER_STATS_EN → counters always 0.

Source files
------------

// File: rtl/branch_outcome_tracker.sv
// In-order queue of branch predictions; compares each against its resolved outcome and trains the predictor.
// Optional statistics counters are built only when BRANCH_TRACKER_STATS_EN is defined.
//
// state | meaning
// IDLE  | queue empty (count == 0), nothing to resolve
// BUSY  | queue holds at least one unresolved prediction
module branch_outcome_tracker #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_val,
  output logic            pred_rdy,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic            resolve_val,
  output logic            resolve_rdy,
  input  logic            resolve_taken,
  input  logic            flush,
  output logic            update_en,
  output logic            update_val,
  output logic [PC_W-1:0] update_pc,
  output logic            mispredict,
  output logic [31:0]     num_branches,
  output logic [31:0]     num_mispredicts
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            update_en_q, update_en_d;
  logic            update_val_q, update_val_d;
  logic [PC_W-1:0] update_pc_q, update_pc_d;
  logic            mispredict_q, mispredict_d;

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic            taken_mem [DEPTH];

  logic enq_fire, deq_fire, mismatch, squash;

  assign pred_rdy    = (count_q != FULL_CNT);
  assign resolve_rdy = (state_q == BUSY);
  assign enq_fire    = pred_val && pred_rdy;
  assign deq_fire    = resolve_val && resolve_rdy;
  assign mismatch    = deq_fire && (resolve_taken != taken_mem[head_q]);
  assign squash      = mismatch || flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq_fire) head_d = head_q + 1'b1;
    // A squash discards every younger entry, including one enqueued this cycle.
    if (squash) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + 1'b1;
      count_d = count_q + (AW+1)'(enq_fire) - (AW+1)'(deq_fire);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enq_fire && !flush) state_d = BUSY;
      BUSY: if (squash || (deq_fire && !enq_fire && count_q == (AW+1)'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    update_en_d  = deq_fire;
    update_val_d = deq_fire ? resolve_taken : update_val_q;
    update_pc_d  = deq_fire ? pc_mem[head_q] : update_pc_q;
    mispredict_d = mismatch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      update_en_q  <= 1'b0;
      update_val_q <= 1'b0;
      update_pc_q  <= '0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      update_en_q  <= update_en_d;
      update_val_q <= update_val_d;
      update_pc_q  <= update_pc_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (enq_fire && !squash) begin
      pc_mem[tail_q]    <= pred_pc;
      taken_mem[tail_q] <= pred_taken;
    end
  end

  assign update_en  = update_en_q;
  assign update_val = update_val_q;
  assign update_pc  = update_pc_q;
  assign mispredict = mispredict_q;

`ifdef BRANCH_TRACKER_STATS_EN
  logic [31:0] num_branches_q, num_branches_d;
  logic [31:0] num_mispredicts_q, num_mispredicts_d;

  always_comb begin
    num_branches_d    = num_branches_q + 32'(deq_fire);
    num_mispredicts_d = num_mispredicts_q + 32'(mismatch);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_branches_q    <= '0;
      num_mispredicts_q <= '0;
    end else begin
      num_branches_q    <= num_branches_d;
      num_mispredicts_q <= num_mispredicts_d;
    end
  end

  assign num_branches    = num_branches_q;
  assign num_mispredicts = num_mispredicts_q;
`else
  assign num_branches    = 32'd0;
  assign num_mispredicts = 32'd0;
`endif

endmodule
